// File: rtl/cond_flag_unit_if.sv
// Bundle-in / result-out handshake bundle for cond_flag_unit.
// master: the issue side (drives bundles, consumes results).
// slave: the condition unit itself.
interface cond_flag_unit_if #(
   parameter int unsigned LANES = 1,
   parameter int unsigned TAG_W = 6
);
   logic                 in_valid;
   logic                 in_ready;
   logic [4*LANES-1:0]   in_cond;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES-1:0]     out_pass;
   logic [TAG_W-1:0]     out_tag;

   modport master (
      output in_valid, in_cond, in_tag, out_ready,
      input  in_ready, out_valid, out_pass, out_tag
   );

   modport slave (
      input  in_valid, in_cond, in_tag, out_ready,
      output in_ready, out_valid, out_pass, out_tag
   );
endinterface

// File: rtl/cond_flag_unit.sv
// Registered multi-lane ARM condition evaluator with its own NZCV flag register.
// Flag bit order everywhere: [3]=C, [2]=N, [1]=V, [0]=Z.
// Optional build macro: COND_FLAG_BYPASS_EN -- forward flag_wdata into the
// evaluation when a flag write and an accept land in the same cycle.
module cond_flag_unit #(
   parameter int unsigned LANES = 1,
   parameter int unsigned TAG_W = 6,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_we,
   input  logic [3:0]       flag_wdata,
   input  logic             flag_pend,
   output logic [3:0]       flags,
   cond_flag_unit_if.slave  bus,
   output logic [CNT_W-1:0] annul_cnt
);

   logic [3:0]       flags_q;
   logic             out_valid_q;
   logic [LANES-1:0] pass_q;
   logic [LANES-1:0] pass_d;
   logic [TAG_W-1:0] tag_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W+2:0] cnt_sum;
   logic [2:0]       zeros;
   logic [3:0]       eval_flags;
   logic             in_ready;
   logic             accept;

   localparam logic [CNT_W+2:0] CntMax = {3'b000, {CNT_W{1'b1}}};

   function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
      logic c, n, v, z, r;
      c = f[3];
      n = f[2];
      v = f[1];
      z = f[0];
      case (cond)
         4'b0000: r = z;
         4'b0001: r = !z;
         4'b0010: r = c;
         4'b0011: r = !c;
         4'b0100: r = n;
         4'b0101: r = !n;
         4'b0110: r = v;
         4'b0111: r = !v;
         4'b1000: r = c & !z;
         4'b1001: r = !c | z;
         4'b1010: r = (n == v);
         4'b1011: r = (n != v);
         4'b1100: r = !z & (n == v);
         4'b1101: r = z | (n != v);
         4'b1110: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Flag pend stalls intake so a bundle never sees stale flags from an in-flight writer.
   assign in_ready     = (!out_valid_q | bus.out_ready) & !flag_pend;
   assign accept       = bus.in_valid & in_ready;
   assign bus.in_ready = in_ready;

`ifdef COND_FLAG_BYPASS_EN
   // Same-cycle forward of the incoming flag write.
   assign eval_flags = flag_we ? flag_wdata : flags_q;
`else
   assign eval_flags = flags_q;
`endif

   // Evaluate every lane against one shared flag value and count the failing lanes.
   always_comb begin
      pass_d = '0;
      zeros  = 3'd0;
      for (int i = 0; i < LANES; i++) begin
         pass_d[i] = cond_true(bus.in_cond[4*i +: 4], eval_flags);
         if (!pass_d[i]) zeros = zeros + 3'd1;
      end
   end

   // Saturating annul counter next state; widened sum so the clamp test cannot overflow.
   always_comb begin
      cnt_sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, zeros};
      cnt_d   = cnt_q;
      if (accept) begin
         cnt_d = (cnt_sum > CntMax) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
   end

   // Architectural flag register; written regardless of handshake state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (flag_we) begin
         flags_q <= flag_wdata;
      end
   end

   // Output stage: load on accept, drain on consume, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         pass_q      <= '0;
         tag_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         pass_q      <= pass_d;
         tag_q       <= bus.in_tag;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Annul counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign flags         = flags_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_pass  = pass_q;
   assign bus.out_tag   = tag_q;
   assign annul_cnt     = cnt_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: a 4-lane/16-bit-counter instance for the
// main function and a 2-lane/2-bit-counter instance for counter saturation.
module tb_cond_flag_unit;

   logic        clk;
   logic        rst_n;
   logic        flag_we_a, flag_pend_a, flag_we_b, flag_pend_b;
   logic [3:0]  flag_wdata_a, flag_wdata_b;
   logic [3:0]  flags_a, flags_b;
   logic [15:0] annul_a;
   logic [1:0]  annul_b;
   int          checks;
   int          failures;
   logic [3:0]  byp_pass;
   logic [15:0] byp_cnt;

   cond_flag_unit_if #(.LANES(4), .TAG_W(6)) bus_a ();
   cond_flag_unit_if #(.LANES(2), .TAG_W(6)) bus_b ();

   cond_flag_unit #(.LANES(4), .TAG_W(6), .CNT_W(16)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .flag_we    (flag_we_a),
      .flag_wdata (flag_wdata_a),
      .flag_pend  (flag_pend_a),
      .flags      (flags_a),
      .bus        (bus_a),
      .annul_cnt  (annul_a)
   );

   cond_flag_unit #(.LANES(2), .TAG_W(6), .CNT_W(2)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .flag_we    (flag_we_b),
      .flag_wdata (flag_wdata_b),
      .flag_pend  (flag_pend_b),
      .flags      (flags_b),
      .bus        (bus_b),
      .annul_cnt  (annul_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [15:0] cond, input logic [5:0] tag);
      bus_a.in_valid = v;
      bus_a.in_cond  = cond;
      bus_a.in_tag   = tag;
   endtask

   task automatic drive_b(input logic v, input logic [7:0] cond, input logic [5:0] tag);
      bus_b.in_valid = v;
      bus_b.in_cond  = cond;
      bus_b.in_tag   = tag;
   endtask

   initial begin
      checks = 0;
      failures = 0;
`ifdef COND_FLAG_BYPASS_EN
      byp_pass = 4'b1111;
      byp_cnt  = 16'd16;
`else
      byp_pass = 4'b0000;
      byp_cnt  = 16'd20;
`endif
      rst_n = 1'b0;
      flag_we_a = 0; flag_pend_a = 0; flag_wdata_a = 4'h0;
      flag_we_b = 0; flag_pend_b = 0; flag_wdata_b = 4'h0;
      drive_a(1'b0, 16'h0000, 6'd0);
      drive_b(1'b0, 8'h00, 6'd0);
      bus_a.out_ready = 1'b1;
      bus_b.out_ready = 1'b1;
      #1;
      chk("rst_flags", 32'(flags_a), 32'h0);
      chk("rst_valid", 32'(bus_a.out_valid), 32'h0);
      chk("rst_annul", 32'(annul_a), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("idle_valid", 32'(bus_a.out_valid), 32'h0);
      chk("idle_pass", 32'(bus_a.out_pass), 32'h0);
      chk("idle_tag", 32'(bus_a.out_tag), 32'h0);

      // EQ on all lanes with Z=0: every lane fails.
      drive_a(1'b1, 16'h0000, 6'd1);
      #1 chk("eq_ready", 32'(bus_a.in_ready), 32'h1);
      tick();
      chk("eq_valid", 32'(bus_a.out_valid), 32'h1);
      chk("eq_pass", 32'(bus_a.out_pass), 32'h0);
      chk("eq_tag", 32'(bus_a.out_tag), 32'd1);
      chk("eq_annul", 32'(annul_a), 32'd4);

      // Write C=1,Z=1; result drains since nothing accepted.
      drive_a(1'b0, 16'h0000, 6'd0);
      flag_we_a = 1'b1; flag_wdata_a = 4'b1001;
      tick();
      flag_we_a = 1'b0;
      chk("wr_flags", 32'(flags_a), 32'h9);
      chk("drain_valid", 32'(bus_a.out_valid), 32'h0);

      // All 16 codes, back-to-back.
      drive_a(1'b1, 16'h3210, 6'd2);
      tick();
      chk("c0_3_pass", 32'(bus_a.out_pass), 32'b0101);
      chk("c0_3_tag", 32'(bus_a.out_tag), 32'd2);
      drive_a(1'b1, 16'h7654, 6'd3);
      #1 chk("b2b_ready", 32'(bus_a.in_ready), 32'h1);
      tick();
      chk("c4_7_pass", 32'(bus_a.out_pass), 32'b1010);
      drive_a(1'b1, 16'hBA98, 6'd4);
      tick();
      chk("c8_11_pass", 32'(bus_a.out_pass), 32'b0110);
      drive_a(1'b1, 16'hFEDC, 6'd5);
      tick();
      chk("c12_15_pass", 32'(bus_a.out_pass), 32'b0110);
      chk("c12_15_tag", 32'(bus_a.out_tag), 32'd5);
      chk("codes_annul", 32'(annul_a), 32'd12);

      // Consumer stall for three cycles.
      drive_a(1'b1, 16'hEEEE, 6'd6);
      bus_a.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_ready", 32'(bus_a.in_ready), 32'h0);
         tick();
         chk("stall_valid", 32'(bus_a.out_valid), 32'h1);
         chk("stall_tag", 32'(bus_a.out_tag), 32'd5);
         chk("stall_pass", 32'(bus_a.out_pass), 32'b0110);
      end
      bus_a.out_ready = 1'b1;
      #1 chk("unstall_ready", 32'(bus_a.in_ready), 32'h1);
      tick();
      chk("unstall_tag", 32'(bus_a.out_tag), 32'd6);
      chk("unstall_pass", 32'(bus_a.out_pass), 32'b1111);
      chk("unstall_annul", 32'(annul_a), 32'd12);

      // flag_pend blocks intake; a flag write still lands meanwhile.
      drive_a(1'b1, 16'hFFFF, 6'd7);
      flag_pend_a = 1'b1;
      flag_we_a = 1'b1; flag_wdata_a = 4'b0000;
      #1 chk("pend_ready", 32'(bus_a.in_ready), 32'h0);
      tick();
      flag_we_a = 1'b0;
      chk("pend_valid", 32'(bus_a.out_valid), 32'h0);
      chk("pend_annul", 32'(annul_a), 32'd12);
      chk("pend_flags", 32'(flags_a), 32'h0);
      flag_pend_a = 1'b0;
      #1 chk("unpend_ready", 32'(bus_a.in_ready), 32'h1);
      tick();
      chk("unpend_tag", 32'(bus_a.out_tag), 32'd7);
      chk("nv_pass", 32'(bus_a.out_pass), 32'b0000);
      chk("nv_annul", 32'(annul_a), 32'd16);

      // Flag write coinciding with an EQ accept.
      drive_a(1'b1, 16'h0000, 6'd8);
      flag_we_a = 1'b1; flag_wdata_a = 4'b0001;
      tick();
      flag_we_a = 1'b0;
      drive_a(1'b0, 16'h0000, 6'd0);
      chk("byp_pass", 32'(bus_a.out_pass), 32'(byp_pass));
      chk("byp_annul", 32'(annul_a), 32'(byp_cnt));
      chk("byp_flags", 32'(flags_a), 32'h1);

      // Narrow counter saturates.
      drive_b(1'b1, 8'hFF, 6'd1);
      tick();
      chk("sat_1", 32'(annul_b), 32'd2);
      drive_b(1'b1, 8'hFF, 6'd2);
      tick();
      chk("sat_2", 32'(annul_b), 32'd3);
      drive_b(1'b1, 8'hFF, 6'd3);
      tick();
      chk("sat_3", 32'(annul_b), 32'd3);
      chk("sat_tag", 32'(bus_b.out_tag), 32'd3);

      // Reset mid-stall clears everything without a clock edge.
      drive_b(1'b1, 8'hEE, 6'd4);
      bus_b.out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(bus_b.out_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(bus_b.out_valid), 32'h0);
      chk("mr_pass", 32'(bus_b.out_pass), 32'h0);
      chk("mr_tag", 32'(bus_b.out_tag), 32'h0);
      chk("mr_annul", 32'(annul_b), 32'h0);
      chk("mr_flags_a", 32'(flags_a), 32'h0);
      chk("mr_annul_a", 32'(annul_a), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
